rr_arb16: RTL
=============

Name: rr_arb16

Overview:
16-way round-robin arbiter that shares one resource (e.g. a row/bank selected by a 4-to-16 one-hot decode) between 16 requesters. Issues a registered one-hot grant plus its 4-bit index, holds it until the owner finishes, drops its request, or exceeds a hold limit. Priority then rotates. Sits between the requesting engines and the shared datapath select logic.

Parameters:
MAX_HOLD, 0, maximum cycles a grant may be held; 0 = unlimited (no timeout)
HOLD_W, 8, width of hold counter; MAX_HOLD must be < 2^HOLD_W

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
arb_en  input  1  1 = new grants may be issued; 0 = no new grants, current grant still completes
req  input  16  request vector, bit i = requester i
done  input  1  current owner finished; sampled only in GRANT
gnt  output  16  one-hot grant, all-zero when idle
gnt_idx  output  4  binary index of granted requester; 0 when idle
gnt_vld  output  1  1 while a grant is held (equals |gnt)
timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD

Behaviour:
- Reset (async assert, sync-deassert by upstream): state=IDLE, gnt=0, gnt_idx=0, gnt_vld=0, timeout=0, ptr=0, hold_cnt=0. Reset mid-grant drops the grant immediately.
- All outputs registered. No combinational path from req/done to any output.
- State IDLE:
  - If arb_en=1 and |req=1: winner = first set bit of req searching from ptr upward, wrapping 15->0.
  - Next cycle: state=GRANT, gnt=1<<winner, gnt_idx=winner, gnt_vld=1, hold_cnt=0.
  - Latency: req rise at edge N -> gnt visible after edge N+1.
  - Otherwise remain IDLE, outputs 0.
- State GRANT: hold_cnt increments each cycle, saturating at all-ones. Release occurs at the first edge where any of the following holds:
  - (a) done=1;
  - (b) req[gnt_idx]=0;
  - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1.
- On release:
  - state=IDLE; gnt, gnt_idx, gnt_vld cleared.
  - ptr = (gnt_idx+1) mod 16, so 15 wraps to 0.
  - timeout=1 for exactly that cycle only when (c) is the sole cause.
  - If done or req drop coincides with (c), timeout=0.
- Grant length: a grant lasts MAX_HOLD cycles when timed out, and at least 1 cycle.
- Back-to-back: one mandatory idle cycle (gnt=0) between successive grants; avoids select overlap on the shared resource.
- Changes to other req bits during GRANT do not affect the current grant.
- arb_en falling during GRANT does not cut the grant; it only blocks the next one.
- done in IDLE is ignored.
- ptr updates only on release, never in IDLE.
- Invariant: gnt is zero or exactly one-hot; gnt[gnt_idx]==gnt_vld.

Test Plan:
- Reset then req=16'h0001, arb_en=1 -> 1 cycle later gnt=16'h0001, gnt_idx=0, gnt_vld=1; pulse done -> next cycle gnt=0, ptr=1.
- req=16'hFFFF held, done pulsed 1 cycle after each grant -> grant sequence idx 0,1,2,...,15,0 with one zero-gnt cycle between each, wrap 15->0 verified.
- After a grant to idx 5 is released, req=16'h0021 -> next grant idx 5? no: ptr=6, search wraps -> gnt_idx=0, then following grant gnt_idx=5.
- MAX_HOLD=4, req=16'h0100, done never asserted -> gnt=16'h0100 for exactly 4 cycles, timeout=1 for one cycle at release, then re-grant idx 8 after one idle cycle.
- Grant on idx 3, drop req[3] with no done -> gnt cleared next cycle, timeout=0, ptr=4; separately, assert done together with timeout edge -> timeout=0.
- arb_en=0 with req=16'h0F00 -> gnt stays 0; rst_n pulsed low mid-grant -> gnt=0 asynchronously, after release the first grant resumes at idx 8 (ptr reset to 0).

Source files
------------

// File: rtl/rr_arb16.sv
// rr_arb16: 16-way round-robin arbiter with a registered one-hot grant, its
// binary index, an optional hold-time limit and a timeout pulse on forced
// release. Exactly one idle cycle separates successive grants.
module rr_arb16 #(
    parameter int unsigned MAX_HOLD = 0,  // 0 = no hold limit
    parameter int unsigned HOLD_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arb_en,
    input  logic [15:0] req,
    input  logic        done,
    output logic [15:0] gnt,
    output logic [3:0]  gnt_idx,
    output logic        gnt_vld,
    output logic        timeout
);

    typedef enum logic {StIdle, StGrant} state_e;

    state_e              state_q;
    logic [3:0]          ptr_q;
    logic [HOLD_W-1:0]   hold_cnt_q;
    logic [15:0]         gnt_q;
    logic [3:0]          idx_q;
    logic                vld_q;
    logic                timeout_q;

    logic [3:0]          winner;
    logic [3:0]          cand;
    logic                found;
    logic                user_rel;
    logic                hold_hit;
    logic                release_now;

    // Rotating priority search: first requester at or above ptr, wrapping 15->0.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cand = ptr_q + 4'(i);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Release causes: owner finished or withdrew, or the hold limit expired.
    always_comb begin
        user_rel    = done | ~req[idx_q];
        hold_hit    = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
        release_now = user_rel | hold_hit;
    end

    // Arbitration FSM; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            idx_q      <= '0;
            vld_q      <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    timeout_q <= 1'b0;
                    if (arb_en && found) begin
                        state_q    <= StGrant;
                        gnt_q      <= 16'b1 << winner;
                        idx_q      <= winner;
                        vld_q      <= 1'b1;
                        hold_cnt_q <= '0;
                    end
                end
                StGrant: begin
                    if (release_now) begin
                        state_q    <= StIdle;
                        gnt_q      <= '0;
                        idx_q      <= '0;
                        vld_q      <= 1'b0;
                        hold_cnt_q <= '0;
                        ptr_q      <= idx_q + 4'd1;
                        // Pulse only when the hold limit alone forced the release.
                        timeout_q  <= ~user_rel;
                    end else begin
                        timeout_q <= 1'b0;
                        if (hold_cnt_q != '1) begin
                            hold_cnt_q <= hold_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign gnt_vld = vld_q;
    assign timeout = timeout_q;

endmodule
